execute_stage: RTL
==================

# execute_stage

Execute stage of the pipelined core, directly downstream of the decode/execute pipeline register. Consumes the registered operands, command and control flags, computes the ALU result (single-cycle ops) or runs an iterative shift-add multiplier (multi-cycle ops), and loads the execute/memory pipeline register. Back-pressures the decode/execute register with `stall` while a multiply is in flight and honours a pipeline flush.

## Interface
- `DATA_W`, 32, operand/result width
- `CMD_W`, 4, execute command width

- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream slot holds a real instruction
- `exe_cmd`  in  CMD_W  execute command
- `val1`, `val2`  in  DATA_W  ALU operands
- `st_data`  in  DATA_W  store data, passed through
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`, `br_taken_in`  in  1 each  control flags, passed through
- `flush`  in  1  kill current stage contents
- `stall`  out  1  upstream must hold its register
- `out_valid`  out  1  EX/MEM slot valid
- `alu_result`  out  DATA_W  registered result
- `st_val`  out  DATA_W  registered store data
- `mem_r_en`, `mem_w_en`, `wb_en`, `br_taken`  out  1 each  registered flags, forced 0 when `out_valid`=0

## Operation
- Commands: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount `val2[4:0]`), 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low DATA_W of product), 11 MULHU (high DATA_W, unsigned), 12 PASS (`val2`), 13–15 NOP (result 0, `wb_en` forced 0).
- ADD/SUB wrap modulo 2^DATA_W; no flags.
- FSM: IDLE, BUSY.
  - IDLE, `in_valid`=1, cmd 10/11: capture `val1`, `val2`, cmd and pass-through fields; clear 2·DATA_W accumulator; `cnt`←0; go BUSY; EX/MEM loads a bubble.
  - IDLE, any other cmd: EX/MEM loads result and flags, `out_valid`←`in_valid`.
  - BUSY: one shift-add iteration per edge (multiplier LSB-first), `cnt`++; EX/MEM holds bubble. On the edge with `cnt`=DATA_W−1, final iteration completes, EX/MEM loads selected product half with captured flags, `out_valid`←1, go IDLE.
- `stall` = (state == BUSY); combinational from state only.
- `flush`=1 at an edge: highest priority; EX/MEM loads bubble, FSM→IDLE, `cnt`←0, in-flight multiply discarded; inputs ignored that edge.
- `in_valid`=0: bubble loaded, FSM unaffected.

## Timing
- Reset (`rst`=0, async): all outputs 0, `stall`=0, FSM IDLE, `cnt`=0, accumulator 0. Deassertion is synchronous to the next edge's behaviour.
- Single-cycle ops: inputs at edge N → outputs valid after edge N; one instruction per cycle.
- Multiply accepted at edge E0: `stall`=1 after E0 through edge E32 (32 cycles at DATA_W=32); result visible after E32; next held instruction accepted at E33.
- Reset mid-multiply: immediate abort, outputs 0.
- Flush coincident with final iteration: flush wins, no result emitted.

## Configuration
- `EXECUTE_MUL_EN` defined: iterative multiplier, BUSY state and `stall` as above.
- Undefined: multiplier, accumulator and counter removed; FSM stays IDLE; `stall` tied 0; cmd 10/11 execute single-cycle as NOP (result 0, `wb_en` 0, `out_valid` follows `in_valid`).

## Test plan
- Reset mid-operation: drive `rst`=0 between edges while BUSY → all outputs 0 and `stall`=0 immediately, before the next edge.
- ADD 0xFFFF_FFFF + 1, `wb_en_in`=1 → after one edge `alu_result`=0, `wb_en`=1, `out_valid`=1; SRA 0x8000_0000 by 4 → 0xF800_0000; SLT −1 vs 1 → 1, SLTU → 0.
- MUL 0x0001_0000 × 0x0001_0000 then MULHU same → `stall` high exactly 32 cycles each; MUL result 0, MULHU result 1; instruction held behind each issues on the cycle after `stall` falls.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE; MUL → 0x0000_0001.
- Flush at iteration 10 of a multiply → `stall` low next cycle, no result, `out_valid`=0; following ADD 2+3 → 5 one edge later.
- Build without `EXECUTE_MUL_EN`: MUL 3×4 → `stall` never high, `alu_result`=0, `wb_en`=0, `out_valid`=1.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Single-cycle ALU commands load EX/MEM directly. MUL/MULHU use an iterative
// LSB-first shift-add multiplier, one iteration per clock.
// Optional build macro: EXECUTE_MUL_EN. When it is undefined the multiplier, BUSY
// state and stall are removed, and MUL/MULHU execute as NOP.
// Handshake: the ID/EX register offers an instruction with in_valid. While stall=1
// it must hold that instruction unchanged. The held instruction is consumed on the
// first rising edge where stall=0. There is no separate ready signal: stall is ~ready.
module execute_stage #(
   parameter int DATA_W = 32,
   parameter int CMD_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [CMD_W-1:0]  exe_cmd,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic [DATA_W-1:0] st_data,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   input  logic              br_taken_in,
   input  logic              flush,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_val,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic              br_taken,
   output logic              dbg_state
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_SUB  = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_OR   = CMD_W'(3);
   localparam logic [CMD_W-1:0] CMD_XOR  = CMD_W'(4);
   localparam logic [CMD_W-1:0] CMD_SLL  = CMD_W'(5);
   localparam logic [CMD_W-1:0] CMD_SRL  = CMD_W'(6);
   localparam logic [CMD_W-1:0] CMD_SRA  = CMD_W'(7);
   localparam logic [CMD_W-1:0] CMD_SLT  = CMD_W'(8);
   localparam logic [CMD_W-1:0] CMD_SLTU = CMD_W'(9);
   localparam logic [CMD_W-1:0] CMD_PASS = CMD_W'(12);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W-1:0] alu_comb;
   logic              alu_wb_ok;
   logic              is_mul;
   logic              last_iter;
   logic [DATA_W-1:0] mul_out;
   logic [DATA_W-1:0] mul_st;
   logic [3:0]        mul_flags;   // {mem_r, mem_w, wb, br}

   logic              ov_d;
   logic [DATA_W-1:0] res_d;
   logic [DATA_W-1:0] st_d;
   logic [3:0]        flags_d;     // {mem_r, mem_w, wb, br}

   assign shamt = val2[SH_W-1:0];

   // Single-cycle ALU. Unknown commands, and MUL/MULHU in the default build, act as NOP.
   always_comb begin
      alu_comb  = '0;
      alu_wb_ok = 1'b1;
      case (exe_cmd)
         CMD_ADD:  alu_comb = val1 + val2;
         CMD_SUB:  alu_comb = val1 - val2;
         CMD_AND:  alu_comb = val1 & val2;
         CMD_OR:   alu_comb = val1 | val2;
         CMD_XOR:  alu_comb = val1 ^ val2;
         CMD_SLL:  alu_comb = val1 << shamt;
         CMD_SRL:  alu_comb = val1 >> shamt;
         CMD_SRA:  alu_comb = $signed(val1) >>> shamt;
         CMD_SLT:  alu_comb = DATA_W'($signed(val1) < $signed(val2));
         CMD_SLTU: alu_comb = DATA_W'(val1 < val2);
         CMD_PASS: alu_comb = val2;
         default:  alu_wb_ok = 1'b0;
      endcase
   end

`ifdef EXECUTE_MUL_EN
   localparam logic [CMD_W-1:0] CMD_MUL   = CMD_W'(10);
   localparam logic [CMD_W-1:0] CMD_MULHU = CMD_W'(11);

   logic [SH_W-1:0]     cnt_q;
   logic [2*DATA_W-1:0] acc_q;
   logic [2*DATA_W-1:0] acc_step;
   logic [DATA_W-1:0]   mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic [DATA_W-1:0]   cap_st_q;
   logic [3:0]          cap_flags_q;
   logic                cap_hi_q;

   assign is_mul    = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_MULHU);
   assign last_iter = (state_q == S_BUSY) && (cnt_q == SH_W'(DATA_W - 1));

   // One shift-add step: multiplier bit cnt selects whether multiplicand<<cnt is added.
   always_comb begin
      acc_step = acc_q;
      if (mplier_q[cnt_q]) begin
         acc_step = acc_q + ({{DATA_W{1'b0}}, mcand_q} << cnt_q);
      end
   end

   assign mul_out   = cap_hi_q ? acc_step[2*DATA_W-1:DATA_W] : acc_step[DATA_W-1:0];
   assign mul_st    = cap_st_q;
   assign mul_flags = cap_flags_q;

   // Multiplier operands, captured side-band fields, accumulator and iteration counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cap_st_q    <= '0;
         cap_flags_q <= '0;
         cap_hi_q    <= 1'b0;
      end else if (flush) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else if (state_q == S_IDLE) begin
         cnt_q <= '0;
         acc_q <= '0;
         if (in_valid && is_mul) begin
            mcand_q     <= val1;
            mplier_q    <= val2;
            cap_st_q    <= st_data;
            cap_flags_q <= {mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in};
            cap_hi_q    <= (exe_cmd == CMD_MULHU);
         end
      end else begin
         acc_q <= acc_step;
         cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
      end
   end
`else
   assign is_mul    = 1'b0;
   assign last_iter = 1'b0;
   assign mul_out   = '0;
   assign mul_st    = '0;
   assign mul_flags = '0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM next state: flush aborts, a valid multiply enters BUSY, the last iteration leaves it.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
         if (in_valid && is_mul) state_d = S_BUSY;
      end else if (last_iter) begin
         state_d = S_IDLE;
      end
   end

   // FSM outputs: the value EX/MEM loads next. The default is a bubble with all fields zero.
   always_comb begin
      ov_d    = 1'b0;
      res_d   = '0;
      st_d    = '0;
      flags_d = '0;
      if (!flush) begin
         if (state_q == S_BUSY) begin
            if (last_iter) begin
               ov_d    = 1'b1;
               res_d   = mul_out;
               st_d    = mul_st;
               flags_d = mul_flags;
            end
         end else if (in_valid && !is_mul) begin
            ov_d    = 1'b1;
            res_d   = alu_comb;
            st_d    = st_data;
            flags_d = {mem_r_en_in, mem_w_en_in, wb_en_in & alu_wb_ok, br_taken_in};
         end
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         alu_result <= '0;
         st_val     <= '0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         wb_en      <= 1'b0;
         br_taken   <= 1'b0;
      end else begin
         out_valid  <= ov_d;
         alu_result <= res_d;
         st_val     <= st_d;
         {mem_r_en, mem_w_en, wb_en, br_taken} <= flags_d;
      end
   end

   assign stall     = (state_q == S_BUSY);
   assign dbg_state = state_q;

endmodule
